// File: rtl/rns_to_bin.sv
// rns_to_bin: sequential CRT reverse converter, one residue channel per cycle.
// Optional macro RNS_TO_BIN_SIGNED_EN maps results >= ceil(M/2) to negative two's complement.
`timescale 1ns/1ps
module rns_to_bin #(
  parameter int unsigned M3 = 251,
  parameter int unsigned M2 = 241,
  parameter int unsigned M1 = 239,
  parameter int unsigned M0 = 233
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rns,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_bin,
  output logic        out_err
);
  localparam int unsigned RES_W = 8;
  localparam int unsigned BIN_W = 32;

  // Modular inverse of a mod m by extended Euclid.
  function automatic longint f_inv(input longint a, input longint m);
    longint old_r, r, old_s, s, q, tmp;
    old_r = a % m;
    r     = m;
    old_s = 1;
    s     = 0;
    while (r != 0) begin
      q     = old_r / r;
      tmp   = r;
      r     = old_r - q * r;
      old_r = tmp;
      tmp   = s;
      s     = old_s - q * s;
      old_s = tmp;
    end
    return ((old_s % m) + m) % m;
  endfunction

  function automatic longint f_big(input longint m_all, input longint m);
    return m_all / m;
  endfunction

  localparam longint M_ALL = longint'(M3) * longint'(M2) * longint'(M1) * longint'(M0);
  localparam logic [BIN_W-1:0] M_W  = BIN_W'(M_ALL);
  localparam logic [BIN_W-1:0] BIG0 = BIN_W'(f_big(M_ALL, longint'(M0)));
  localparam logic [BIN_W-1:0] BIG1 = BIN_W'(f_big(M_ALL, longint'(M1)));
  localparam logic [BIN_W-1:0] BIG2 = BIN_W'(f_big(M_ALL, longint'(M2)));
  localparam logic [BIN_W-1:0] BIG3 = BIN_W'(f_big(M_ALL, longint'(M3)));
  localparam logic [RES_W-1:0] INV0 = RES_W'(f_inv(f_big(M_ALL, longint'(M0)), longint'(M0)));
  localparam logic [RES_W-1:0] INV1 = RES_W'(f_inv(f_big(M_ALL, longint'(M1)), longint'(M1)));
  localparam logic [RES_W-1:0] INV2 = RES_W'(f_inv(f_big(M_ALL, longint'(M2)), longint'(M2)));
  localparam logic [RES_W-1:0] INV3 = RES_W'(f_inv(f_big(M_ALL, longint'(M3)), longint'(M3)));
`ifdef RNS_TO_BIN_SIGNED_EN
  localparam logic [BIN_W-1:0] HALF = BIN_W'((M_ALL + 1) / 2);
`endif

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t             r_state, w_state_nxt;
  logic [BIN_W-1:0]   r_rns, w_rns_nxt;
  logic [BIN_W-1:0]   r_acc, w_acc_nxt;
  logic [1:0]         r_k, w_k_nxt;
  logic               r_err, w_err_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [BIN_W-1:0]   r_out_bin, w_out_bin_nxt;
  logic               r_out_err, w_out_err_nxt;

  logic               w_in_ready;
  logic               w_in_err;
  logic [RES_W-1:0]   w_r, w_m, w_i, w_t;
  logic [BIN_W-1:0]   w_big, w_term, w_acc_sum, w_final;
  logic [2*RES_W-1:0] w_prod;
  logic [BIN_W:0]     w_sum;

  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_in_err   = (in_rns[7:0]   >= RES_W'(M0)) || (in_rns[15:8]  >= RES_W'(M1)) ||
                      (in_rns[23:16] >= RES_W'(M2)) || (in_rns[31:24] >= RES_W'(M3));

  // Channel select: residue, modulus, inverse and partial product weight for step k.
  always_comb begin
    w_r   = r_rns[7:0];
    w_m   = RES_W'(M0);
    w_i   = INV0;
    w_big = BIG0;
    case (r_k)
      2'd1: begin w_r = r_rns[15:8];  w_m = RES_W'(M1); w_i = INV1; w_big = BIG1; end
      2'd2: begin w_r = r_rns[23:16]; w_m = RES_W'(M2); w_i = INV2; w_big = BIG2; end
      2'd3: begin w_r = r_rns[31:24]; w_m = RES_W'(M3); w_i = INV3; w_big = BIG3; end
      default: ;
    endcase
  end

  // t*Mk < M < 2^32, so the 32-bit product is exact; the 33-bit sum needs one correction.
  assign w_prod    = (2*RES_W)'(w_r) * (2*RES_W)'(w_i);
  assign w_t       = RES_W'(w_prod % (2*RES_W)'(w_m));
  assign w_term    = BIN_W'(w_t) * w_big;
  assign w_sum     = (BIN_W+1)'(r_acc) + (BIN_W+1)'(w_term);
  assign w_acc_sum = (w_sum >= (BIN_W+1)'(M_ALL)) ? BIN_W'(w_sum - (BIN_W+1)'(M_ALL)) : w_sum[BIN_W-1:0];

`ifdef RNS_TO_BIN_SIGNED_EN
  assign w_final = (w_acc_sum >= HALF) ? (w_acc_sum - M_W) : w_acc_sum;
`else
  assign w_final = w_acc_sum;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_rns_nxt       = r_rns;
    w_acc_nxt       = r_acc;
    w_k_nxt         = r_k;
    w_err_nxt       = r_err;
    w_out_valid_nxt = r_out_valid && !out_ready;
    w_out_bin_nxt   = r_out_bin;
    w_out_err_nxt   = r_out_err;
    case (r_state)
      S_IDLE: begin
        if (in_valid && w_in_ready) begin
          w_rns_nxt   = in_rns;
          w_acc_nxt   = '0;
          w_k_nxt     = 2'd0;
          w_err_nxt   = w_in_err;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_acc_nxt = w_acc_sum;
        w_k_nxt   = r_k + 2'd1;
        if (r_k == 2'd3) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b1;
          w_out_bin_nxt   = r_err ? '0 : w_final;
          w_out_err_nxt   = r_err;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rns       <= '0;
      r_acc       <= '0;
      r_k         <= 2'd0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rns       <= w_rns_nxt;
      r_acc       <= w_acc_nxt;
      r_k         <= w_k_nxt;
      r_err       <= w_err_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_bin   <= w_out_bin_nxt;
      r_out_err   <= w_out_err_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_bin   = r_out_bin;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_rns_to_bin.sv
// Self-checking bench for rns_to_bin: directed cases plus random values checked by residue round-trip.
`timescale 1ns/1ps
module tb_rns_to_bin;
  localparam longint MOD3 = 251;
  localparam longint MOD2 = 241;
  localparam longint MOD1 = 239;
  localparam longint MOD0 = 233;
  localparam longint MM   = MOD3 * MOD2 * MOD1 * MOD0;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rns;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_bin;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  rns_to_bin dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rns(in_rns),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: residues of an integer, and the output mapping of a value in 0..M-1.
  function automatic logic [31:0] to_rns(input longint x);
    return {8'(x % MOD3), 8'(x % MOD2), 8'(x % MOD1), 8'(x % MOD0)};
  endfunction

  function automatic logic [31:0] exp_map(input longint x);
`ifdef RNS_TO_BIN_SIGNED_EN
    if (x >= (MM + 1) / 2) return 32'(x - MM);
`endif
    return 32'(x);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one word, check 4-cycle latency and result, optionally stall, then pop.
  task automatic conv(input logic [31:0] word, input logic [31:0] exp_bin, input logic exp_err,
                      input int hold, input string tag);
    int n;
    in_rns   = word;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    in_rns   = $urandom;
    n = 0;
    do begin step(); n++; end while (!out_valid && n < 20);
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_bin"}, out_bin, exp_bin);
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_bin"}, out_bin, exp_bin);
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk({tag, "_pop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    longint      x;
    int          c;
    int          n;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_rns    = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bin", out_bin, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Reset in the middle of a conversion discards it.
    in_rns   = 32'h01010101;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #2;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_ready", 32'(in_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin step(); if (out_valid) n++; end
    chk("midrst_novalid", 32'(n), 32'd0);

    conv(32'h01010101, exp_map(1), 1'b0, 0, "one");
    conv(32'h00000000, exp_map(0), 1'b0, 0, "zero");
    conv({8'd247, 8'd36, 8'd44, 8'd68}, exp_map(1000), 1'b0, 0, "k1000");
`ifdef RNS_TO_BIN_SIGNED_EN
    conv({8'd250, 8'd240, 8'd238, 8'd232}, 32'hFFFFFFFF, 1'b0, 0, "mmax");
    conv({8'd4, 8'd205, 8'd195, 8'd165}, 32'hFFFFFC18, 1'b0, 0, "neg1000");
`else
    conv({8'd250, 8'd240, 8'd238, 8'd232}, 32'd3368562316, 1'b0, 0, "mmax");
    conv({8'd4, 8'd205, 8'd195, 8'd165}, 32'd3368561317, 1'b0, 0, "neg1000");
`endif
    conv({8'd251, 8'd0, 8'd0, 8'd0}, 32'd0, 1'b1, 0, "illegal");
    conv(to_rns(12345), exp_map(12345), 1'b0, 0, "after_err");

    // Stall with a new word waiting, then pop and accept on the same edge.
    in_rns    = to_rns(777);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_rns   = to_rns(4242);
    n = 0;
    do begin step(); n++; end while (!out_valid && n < 20);
    chk("stall_latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("stall_bin", out_bin, exp_map(777));
      chk("stall_rdy", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("pop_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("pop_cleared", 32'(out_valid), 32'd0);
    chk("pop_busy", 32'(in_ready), 32'd0);
    n = 0;
    do begin step(); n++; end while (!out_valid && n < 20);
    chk("next_latency", 32'(n), 32'd4);
    chk("next_bin", out_bin, exp_map(4242));
    step();

    // Random round trip; a quarter of the words carry an illegal residue.
    for (int i = 0; i < 40; i++) begin
      x = longint'($urandom) % MM;
      w = to_rns(x);
      if ($urandom_range(0, 3) == 0) begin
        c = $urandom_range(0, 3);
        case (c)
          0: w[7:0]   = 8'($urandom_range(MOD0, 255));
          1: w[15:8]  = 8'($urandom_range(MOD1, 255));
          2: w[23:16] = 8'($urandom_range(MOD2, 255));
          default: w[31:24] = 8'($urandom_range(MOD3, 255));
        endcase
        conv(w, 32'd0, 1'b1, $urandom_range(0, 3), "rand_err");
      end else begin
        conv(w, exp_map(x), 1'b0, $urandom_range(0, 3), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rns_to_bin.md
Name: rns_to_bin

Overview:
- Reverse converter that sits directly downstream of the RNS Fourier core.
- Takes one packed 4-residue word, which is the y_re or y_im readback of the transform, and reconstructs the binary integer by sequential Chinese Remainder Theorem accumulation.
- Handshake is valid/ready on both sides. A host-side sequencer streams real and imaginary results through it back to back.

Parameters:
- M3, 251, modulus of residue bits [31:24]
- M2, 241, modulus of residue bits [23:16]
- M1, 239, modulus of residue bits [15:8]
- M0, 233, modulus of residue bits [7:0]
- Constraints: moduli pairwise coprime, each ≤255, product M = M3·M2·M1·M0 < 2^32. Default M = 3368562317.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset; 0 asserts
- in_valid  in  1  in_rns holds a word to convert
- in_ready  out  1  converter can accept a word this cycle
- in_rns  in  32  packed residues {r3,r2,r1,r0}
- out_valid  out  1  out_bin/out_err hold a result
- out_ready  in  1  consumer takes the result this cycle
- out_bin  out  32  reconstructed integer
- out_err  out  1  input word contained an illegal residue

Behaviour:
- Constants are elaborated by constant functions, not hand-entered:
  - Mi = M/mi
  - Ii = Mi^-1 mod mi
- Reset (reset=0, asynchronous) forces:
  - state=IDLE
  - out_valid=0, out_bin=0, out_err=0
  - accumulator=0, channel counter=0
- A conversion in flight when reset asserts is discarded. There is no output for it.
- in_ready is combinational: (state==IDLE) && (!out_valid || out_ready). An accept in the same cycle as an output pop is legal.
- State machine:
  - IDLE: on in_valid&&in_ready:
    - latch in_rns
    - acc←0, k←0
    - err←OR over i of (ri ≥ mi)
    - go to CALC
  - CALC, one channel per cycle, k=0..3 in order M0,M1,M2,M3:
    - ti = (rk·Ik) mod mk (8×8 multiply, modulo)
    - term = ti·Mk (< M)
    - s = acc + term, computed in 33 bits
    - acc ← (s ≥ M) ? s−M : s
    - at k=3 go to IDLE, set out_valid=1, out_bin=final acc (0 if err), out_err=err
- Latency: acceptance at edge T gives out_valid=1 after edge T+4. Throughput is one word per 5 cycles without stalls.
- Output hold: out_bin and out_err stay stable while out_valid=1 and out_ready=0. out_valid clears on the edge where out_ready=1, unless a new result completes on that same edge.
- While out_valid=1 and out_ready=0, in_ready=0. No result is ever overwritten.
- in_rns is sampled only at acceptance. Changes afterwards have no effect.
- All arithmetic is unsigned. Result range is 0..M−1.
- Illegal residue (ri ≥ mi): the conversion still takes 5 cycles, out_bin=0 and out_err=1.

Optional Feature:
- Macro: RNS_TO_BIN_SIGNED_EN.
- When defined: after the final CALC step, a result X ≥ ceil(M/2) is output as the 32-bit two's complement of X−M. Values below ceil(M/2) are unchanged. This maps the symmetric RNS range to signed.
- When undefined: out_bin is unsigned 0..M−1.
- Latency and handshake are identical either way.

Test Plan:
- Reset low mid-CALC after accepting {1,1,1,1} -> out_valid stays 0. After release, in_ready=1 and the next word converts normally.
- in_rns={1,1,1,1}, out_ready=1 -> out_bin=1 exactly 4 cycles after acceptance. in_rns=0 -> out_bin=0.
- in_rns={247,36,44,68} (1000) -> out_bin=1000. in_rns={250,240,238,232} -> out_bin=3368562316 unsigned; with RNS_TO_BIN_SIGNED_EN, out_bin=0xFFFFFFFF.
- in_rns={4,205,195,165} (−1000) -> out_bin=3368561317 unsigned; signed build gives 0xFFFFFC18.
- in_rns={251,0,0,0} -> out_err=1, out_bin=0. The next legal word clears out_err.
- out_ready=0 for 10 cycles with in_valid held -> out_bin stable, in_ready=0. Raising out_ready pops the result and the next word is accepted in that same cycle.
